// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and helpers for the reg_file_sb register file.
//   DATA_W_DEF / NREG_DEF / MAX_OUT_DEF : default parameter values
//   PC_IDX     : index of the PC slot (never stored) for the default size
//   reg_addr_t : register address type for the default size
//   cnt_w()    : width of an outstanding-load counter that can hold 0..max_out
package rf_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int NREG_DEF    = 16;
  localparam int MAX_OUT_DEF = 4;
  localparam int PC_IDX      = NREG_DEF - 1;

  typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;

  function automatic int cnt_w(input int max_out);
    return (max_out < 1) ? 1 : $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: busy-bit scoreboard for outstanding loads.
//   CLK, RESETn          : clock, asynchronous active-low reset
//   SB_SET, SB_ADDR      : load issued, destination register to mark busy
//   WE_B, WA_B           : load-return write; clears the busy bit it targets
//   busy_vis_o           : busy vector as seen by readers (PC bit always 0)
//   SB_FULL, SB_CNT      : outstanding-load count and count==MAX_OUT flag
// Macro RF_BYPASS_EN: when defined, a bit being cleared this cycle already
// reads as not busy on busy_vis_o; otherwise busy_vis_o is the registered bits.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int ADDR_W  = $clog2(NREG),
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic                        CLK,
  input  logic                        RESETn,
  input  logic                        SB_SET,
  input  logic [ADDR_W-1:0]           SB_ADDR,
  input  logic                        WE_B,
  input  logic [ADDR_W-1:0]           WA_B,
  output logic [NREG-1:0]             busy_vis_o,
  output logic                        SB_FULL,
  output logic [cnt_w(MAX_OUT)-1:0]   SB_CNT
);

  localparam int CNT_W = cnt_w(MAX_OUT);
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(NREG - 1);

  logic [NREG-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full;
  logic             set_ok, clr_ok, reload, clr_eff;

  assign full = (cnt_q == CNT_W'(MAX_OUT));

  always_comb begin
    set_ok  = SB_SET && !full && (SB_ADDR != PC_A) && !busy_q[SB_ADDR];
    clr_ok  = WE_B && (WA_B != PC_A) && busy_q[WA_B];
    // A new load to the register whose previous load is returning now keeps
    // the bit set and the count level: one load retires, one is issued.
    reload  = clr_ok && SB_SET && (SB_ADDR == WA_B);
    clr_eff = clr_ok && !reload;

    busy_d = busy_q;
    if (clr_eff) busy_d[WA_B] = 1'b0;
    if (set_ok)  busy_d[SB_ADDR] = 1'b1;

    cnt_d = cnt_q;
    if (set_ok && !clr_eff && !full)
      cnt_d = cnt_q + 1'b1;
    else if (clr_eff && !set_ok && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    busy_vis_o = busy_q;
`ifdef RF_BYPASS_EN
    if (clr_eff) busy_vis_o[WA_B] = 1'b0;
`endif
  end

  assign SB_FULL = full;
  assign SB_CNT  = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with load scoreboard.
//   CLK, RESETn        : clock, asynchronous active-low reset
//   RA / RD / BUSY     : NRD packed combinational read ports and busy flags
//   R15                : value returned for the PC index (NREG-1)
//   WE_A, WA_A, WD_A   : ALU writeback port (wins over B on same address)
//   WE_B, WA_B, WD_B   : load-return writeback port (clears busy bit)
//   SB_SET, SB_ADDR    : load issued, mark destination busy
//   SB_FULL, SB_CNT    : scoreboard occupancy
// Macro RF_BYPASS_EN: when defined, reads forward same-cycle write data
// (A over B) and BUSY shows a same-cycle clear; otherwise reads see stored
// contents and registered busy bits only.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int ADDR_W  = $clog2(NREG),
  parameter int NRD     = 3,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic                        CLK,
  input  logic                        RESETn,
  input  logic [NRD*ADDR_W-1:0]       RA,
  output logic [NRD*DATA_W-1:0]       RD,
  output logic [NRD-1:0]              BUSY,
  input  logic [DATA_W-1:0]           R15,
  input  logic                        WE_A,
  input  logic [ADDR_W-1:0]           WA_A,
  input  logic [DATA_W-1:0]           WD_A,
  input  logic                        WE_B,
  input  logic [ADDR_W-1:0]           WA_B,
  input  logic [DATA_W-1:0]           WD_B,
  input  logic                        SB_SET,
  input  logic [ADDR_W-1:0]           SB_ADDR,
  output logic                        SB_FULL,
  output logic [cnt_w(MAX_OUT)-1:0]   SB_CNT
);

  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(NREG - 1);

  logic [DATA_W-1:0] mem_q [NREG-1];
  logic [NREG-1:0]   busy_vis;
  logic              wr_a, wr_b;

  assign wr_a = WE_A && (WA_A != PC_A);
  // Port B loses the data slot when A writes the same register.
  assign wr_b = WE_B && (WA_B != PC_A) && !(wr_a && (WA_A == WA_B));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < NREG - 1; i++) mem_q[i] <= '0;
    end else begin
      if (wr_b) mem_q[WA_B] <= WD_B;
      if (wr_a) mem_q[WA_A] <= WD_A;
    end
  end

  rf_scoreboard #(
    .NREG    (NREG),
    .ADDR_W  (ADDR_W),
    .MAX_OUT (MAX_OUT)
  ) u_sb (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .SB_SET     (SB_SET),
    .SB_ADDR    (SB_ADDR),
    .WE_B       (WE_B),
    .WA_B       (WA_B),
    .busy_vis_o (busy_vis),
    .SB_FULL    (SB_FULL),
    .SB_CNT     (SB_CNT)
  );

  always_comb begin
    logic [ADDR_W-1:0] ra;
    RD   = '0;
    BUSY = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = RA[k*ADDR_W +: ADDR_W];
      if (ra == PC_A) begin
        RD[k*DATA_W +: DATA_W] = R15;
      end else begin
        RD[k*DATA_W +: DATA_W] = mem_q[ra];
`ifdef RF_BYPASS_EN
        // Forwarding is held off during reset so stored indices read 0.
        if (RESETn) begin
          if (WE_B && (WA_B == ra)) RD[k*DATA_W +: DATA_W] = WD_B;
          if (WE_A && (WA_A == ra)) RD[k*DATA_W +: DATA_W] = WD_A;
        end
`endif
        BUSY[k] = busy_vis[ra];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  import rf_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 3;

  logic           CLK = 1'b0;
  logic           RESETn;
  logic [NR*AW-1:0] RA;
  logic [NR*DW-1:0] RD;
  logic [NR-1:0]  BUSY;
  logic [DW-1:0]  R15;
  logic           WE_A, WE_B, SB_SET;
  logic [AW-1:0]  WA_A, WA_B, SB_ADDR;
  logic [DW-1:0]  WD_A, WD_B;
  logic           SB_FULL;
  logic [2:0]     SB_CNT;

  int n_chk = 0;
  int n_err = 0;

  reg_file_sb dut (
    .CLK(CLK), .RESETn(RESETn), .RA(RA), .RD(RD), .BUSY(BUSY), .R15(R15),
    .WE_A(WE_A), .WA_A(WA_A), .WD_A(WD_A),
    .WE_B(WE_B), .WA_B(WA_B), .WD_B(WD_B),
    .SB_SET(SB_SET), .SB_ADDR(SB_ADDR), .SB_FULL(SB_FULL), .SB_CNT(SB_CNT)
  );

  always #5 CLK = ~CLK;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ra(input reg_addr_t a0, input reg_addr_t a1, input reg_addr_t a2);
    RA = {a2, a1, a0};
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return RD[k*DW +: DW];
  endfunction

  // Advance past the next rising edge; inputs then change away from the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    WE_A = 0; WE_B = 0; SB_SET = 0;
  endtask

  initial begin
    RESETn = 0; R15 = 32'h100; idle();
    WA_A = 0; WA_B = 0; WD_A = 0; WD_B = 0; SB_ADDR = 0;
    set_ra(0, 5, reg_addr_t'(PC_IDX));
    #12;
    check("rst_rd0", rd(0), 0);
    check("rst_rd1", rd(1), 0);
    check("rst_rd2_pc", rd(2), 32'h100);
    check("rst_busy", BUSY, 0);
    check("rst_cnt", SB_CNT, 0);
    check("rst_full", SB_FULL, 0);
    RESETn = 1;
    step();

    // ALU write with same-cycle read
    WE_A = 1; WA_A = 3; WD_A = 32'hDEAD; set_ra(3, 0, 0); #1;
    check("wa_same_cycle", rd(0), BYP ? 32'hDEAD : 32'h0);
    step(); idle(); #1;
    check("wa_next_cycle", rd(0), 32'hDEAD);

    // Write to PC index is dropped, read returns R15
    WE_A = 1; WA_A = 15; WD_A = 32'hBAD; set_ra(15, 3, 0);
    step(); idle(); #1;
    check("pc_read", rd(0), 32'h100);
    check("pc_busy", BUSY[0], 0);

    // Load to r7, then A and B both write r7
    SB_SET = 1; SB_ADDR = 7; step(); idle(); set_ra(0, 7, 0); #1;
    check("r7_busy", BUSY[1], 1);
    check("r7_cnt", SB_CNT, 1);
    WE_A = 1; WA_A = 7; WD_A = 32'h11; WE_B = 1; WA_B = 7; WD_B = 32'h22; #1;
    check("r7_busy_same", BUSY[1], BYP ? 1'b0 : 1'b1);
    check("r7_rd_same", rd(1), BYP ? 32'h11 : 32'h0);
    step(); idle(); #1;
    check("r7_prio_data", rd(1), 32'h11);
    check("r7_busy_after", BUSY[1], 0);
    check("r7_cnt_after", SB_CNT, 0);

    // Fill scoreboard r1..r4
    for (int r = 1; r <= 4; r++) begin
      SB_SET = 1; SB_ADDR = AW'(r); step();
    end
    idle(); #1;
    check("fill_cnt", SB_CNT, 4);
    check("fill_full", SB_FULL, 1);
    SB_SET = 1; SB_ADDR = 5; step(); idle(); set_ra(5, 1, 4); #1;
    check("full_r5_busy", BUSY[0], 0);
    check("full_r1r4_busy", BUSY[2:1], 2'b11);
    check("full_cnt", SB_CNT, 4);

    // Reload r2 while its load returns
    SB_SET = 1; SB_ADDR = 2; WE_B = 1; WA_B = 2; WD_B = 32'h55;
    step(); idle(); set_ra(2, 0, 0); #1;
    check("reload_busy", BUSY[0], 1);
    check("reload_data", rd(0), 32'h55);
    check("reload_cnt", SB_CNT, 4);

    // Load-return to idle register is a plain write
    WE_B = 1; WA_B = 6; WD_B = 32'h66; step(); idle(); set_ra(6, 0, 0); #1;
    check("plain_b_data", rd(0), 32'h66);
    check("plain_b_cnt", SB_CNT, 4);

    // Return r1: count drops, not full
    WE_B = 1; WA_B = 1; WD_B = 32'h1111; step(); idle(); set_ra(1, 0, 0); #1;
    check("clr_r1_busy", BUSY[0], 0);
    check("clr_r1_cnt", SB_CNT, 3);
    check("clr_r1_full", SB_FULL, 0);

    // Async reset with r2,r3,r4 pending, asserted mid-cycle
    set_ra(2, 3, 4);
    #2 RESETn = 0; #1;
    check("arst_busy", BUSY, 0);
    check("arst_cnt", SB_CNT, 0);
    check("arst_full", SB_FULL, 0);
    check("arst_rd0", rd(0), 0);
    check("arst_rd1", rd(1), 0);
    #3 RESETn = 1;
    step();
    WE_B = 1; WA_B = 3; WD_B = 32'h77; step(); idle(); #1;
    check("post_rst_b_data", rd(1), 32'h77);
    check("post_rst_b_cnt", SB_CNT, 0);

    // Set r9 while r8 returns: count unchanged
    SB_SET = 1; SB_ADDR = 8; step();
    SB_SET = 1; SB_ADDR = 9; WE_B = 1; WA_B = 8; WD_B = 32'h88;
    step(); idle(); set_ra(8, 9, 0); #1;
    check("swap_r8_busy", BUSY[0], 0);
    check("swap_r9_busy", BUSY[1], 1);
    check("swap_cnt", SB_CNT, 1);
    check("swap_r8_data", rd(0), 32'h88);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
